// File: rtl/mem_stall_ctrl_if.sv
// External data-memory port between the stall controller and the memory.
// ext_req_o and the address/data lines stay stable until the memory acks.
interface mem_stall_ctrl_if;
  logic        ext_req_o;
  logic        ext_we_o;
  logic [31:0] ext_addr_o;
  logic [31:0] ext_wdata_o;
  logic        ext_ack_i;
  logic [31:0] ext_rdata_i;

  modport master (
    output ext_req_o, ext_we_o, ext_addr_o, ext_wdata_o,
    input  ext_ack_i, ext_rdata_i
  );
  modport slave (
    input  ext_req_o, ext_we_o, ext_addr_o, ext_wdata_o,
    output ext_ack_i, ext_rdata_i
  );
endinterface

// File: rtl/mem_stall_ctrl.sv
// Pipeline sequencing for the 5-stage core: freezes the pipe during data-memory
// accesses, inserts load-use bubbles and flushes IF/ID on taken branches.
module mem_stall_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  mem_stall_ctrl_if.master ext,
  output logic [31:0] mem_rdata_o,
  input  logic        idex_memread_i,
  input  logic [4:0]  idex_rd_i,
  input  logic [4:0]  ifid_rs1_i,
  input  logic [4:0]  ifid_rs2_i,
  input  logic        branch_taken_i,
  output logic        pc_we_o,
  output logic        ifid_we_o,
  output logic        idex_we_o,
  output logic        exmem_we_o,
  output logic        memwb_we_o,
  output logic        ifid_flush_o,
  output logic        idex_bubble_o,
  output logic [31:0] stall_cnt_o,
  output logic        err_o
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state_q, state_d;
  logic          freeze, loaduse;
  logic          we_q;
  logic [31:0]   addr_q, wdata_q;
  logic [TW-1:0] to_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    freeze        = 1'b0;
    loaduse       = 1'b0;
    pc_we_o       = 1'b1;
    ifid_we_o     = 1'b1;
    idex_we_o     = 1'b1;
    exmem_we_o    = 1'b1;
    memwb_we_o    = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    case (state_q)
      IDLE: if (mem_req_i) begin
        state_d = REQ;
        freeze  = 1'b1;
      end
      REQ: begin
        freeze = 1'b1;
        if (ext.ext_ack_i) state_d = DONE;
      end
      // EX/MEM still holds the completed access, so mem_req_i is ignored here
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (freeze) begin
      pc_we_o    = 1'b0;
      ifid_we_o  = 1'b0;
      idex_we_o  = 1'b0;
      exmem_we_o = 1'b0;
      memwb_we_o = 1'b0;
    end else begin
      loaduse = idex_memread_i && (idex_rd_i != 5'd0) &&
                ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));
      if (loaduse) begin
        pc_we_o       = 1'b0;
        ifid_we_o     = 1'b0;
        idex_bubble_o = 1'b1;
      end
      ifid_flush_o = branch_taken_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_rdata_o <= '0;
      stall_cnt_o <= '0;
      err_o       <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      if (freeze) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (state_q == IDLE && mem_req_i) begin
        we_q     <= mem_we_i;
        addr_q   <= mem_addr_i;
        wdata_q  <= mem_wdata_i;
        to_cnt_q <= '0;
      end
      if (state_q == REQ) begin
        if (ext.ext_ack_i) begin
          if (!we_q) mem_rdata_o <= ext.ext_rdata_i;
        end else begin
          // counter saturates at TIMEOUT; err_o rises on the edge it gets there
          if (32'(to_cnt_q) < TIMEOUT) to_cnt_q <= to_cnt_q + TW'(1);
          if (32'(to_cnt_q) + 32'd1 >= TIMEOUT) err_o <= 1'b1;
        end
      end
    end
  end

  assign ext.ext_req_o   = (state_q == REQ);
  assign ext.ext_we_o    = we_q;
  assign ext.ext_addr_o  = addr_q;
  assign ext.ext_wdata_o = wdata_q;
endmodule

// File: doc/mem_stall_ctrl.md
# mem_stall_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core. It owns the write enables of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It sequences multi-cycle data-memory accesses over a req/ack port and freezes the whole pipeline while an access is outstanding. It also inserts load-use bubbles and flushes IF/ID on taken branches, and keeps a stall-cycle counter and a timeout error flag.

## Interface

- TIMEOUT, 255, max REQ cycles without ack before `err_o` sets (≥1)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous reset, active-high
- mem_req_i  in  1  EX/MEM instruction is a load or store
- mem_we_i  in  1  1 = store, 0 = load; valid with mem_req_i
- mem_addr_i  in  32  EX/MEM ALU result (byte address)
- mem_wdata_i  in  32  store data
- ext_req_o  out  1  external data-memory request
- ext_we_o  out  1  external write enable
- ext_addr_o  out  32  external address
- ext_wdata_o  out  32  external write data
- ext_ack_i  in  1  external completion; rdata valid same cycle
- ext_rdata_i  in  32  external read data
- mem_rdata_o  out  32  captured load data, to MEM/WB MemRdata input
- idex_memread_i  in  1  ID/EX instruction is a load
- idex_rd_i  in  5  ID/EX destination register
- ifid_rs1_i, ifid_rs2_i  in  5 each  IF/ID source registers
- branch_taken_i  in  1  branch resolved taken in ID
- pc_we_o, ifid_we_o, idex_we_o, exmem_we_o, memwb_we_o  out  1 each  register enables
- ifid_flush_o  out  1  IF/ID loads NOP
- idex_bubble_o  out  1  ID/EX loads zero control bits
- stall_cnt_o  out  32  count of memory-freeze cycles
- err_o  out  1  sticky timeout flag

## Operation

- FSM states: IDLE, REQ, DONE.
  - IDLE, mem_req_i=1: go to REQ; latch mem_we_i, mem_addr_i, mem_wdata_i into ext_* registers.
  - REQ, ext_ack_i=1: latch ext_rdata_i into mem_rdata_o (loads only; stores leave it unchanged); go to DONE.
  - REQ, no ack: stay in REQ.
  - DONE: unconditionally go to IDLE. mem_req_i is ignored here, because EX/MEM still holds the completed instruction.
- ext_req_o is high exactly while state is REQ. ext_we_o, ext_addr_o and ext_wdata_o are stable for the whole REQ period.
- ext_ack_i is ignored outside REQ.
- freeze = (IDLE and mem_req_i) or REQ. While freeze is high:
  - all five *_we_o = 0;
  - ifid_flush_o = 0 and idex_bubble_o = 0. The hazard inputs are held by the frozen registers, so these actions are taken after the freeze ends.
- When not frozen:
  - loaduse = idex_memread_i and idex_rd_i≠0 and (idex_rd_i==ifid_rs1_i or idex_rd_i==ifid_rs2_i). On loaduse: pc_we_o=0, ifid_we_o=0, idex_bubble_o=1.
  - branch_taken_i gives ifid_flush_o=1.
  - Load-use and branch can assert together; both actions apply.
  - exmem_we_o and memwb_we_o are always 1.
  - idex_we_o is always 1; the bubble is loaded through the enable.
- stall_cnt_o increments by 1 each freeze cycle, wraps 0xFFFFFFFF→0.
- Timeout counter: cleared on entry to REQ, increments each REQ cycle without ack. When it reaches TIMEOUT, err_o sets and stays set until reset. The FSM remains in REQ; the pipeline stays frozen.

## Timing

- Reset values: state IDLE; ext_req_o=0, ext_we_o=0, ext_addr_o=0, ext_wdata_o=0, mem_rdata_o=0, stall_cnt_o=0, err_o=0, timeout counter 0.
- Outputs derived combinationally from freeze apply during reset: with rst_i=1 and state IDLE, the enables follow the rules above. Reset wins over any concurrent ack or request.
- Reset asserted mid-REQ: next cycle is IDLE with ext_req_o=0. A late ack is ignored.
- Access with ack in the k-th REQ cycle:
  - freeze lasts k+1 cycles (1 IDLE detect + k REQ);
  - the pipeline advances at the end of the DONE cycle;
  - MEM/WB captures mem_rdata_o at that edge.
- Back-to-back memory instructions: the next request is detected in IDLE the cycle after DONE. There is no request in DONE.

## Test plan

- Load at 0x100, ack on 1st REQ cycle, rdata 0xDEADBEEF → 2 freeze cycles. ext_req_o high 1 cycle with addr 0x100, we=0. mem_rdata_o=0xDEADBEEF in DONE. All we=1 in DONE. stall_cnt_o=2.
- Store 0x12345678 to 0x200, ack after 3 REQ cycles → ext_we_o=1 and data stable for 3 cycles. 4 freeze cycles. mem_rdata_o unchanged.
- Load-use: idex_memread_i=1, idex_rd_i=5, ifid_rs2_i=5, no mem_req_i → pc_we_o=0, ifid_we_o=0, idex_bubble_o=1 for one cycle. With idex_rd_i=0 there is no stall.
- Branch taken during freeze → ifid_flush_o stays 0 until DONE, then asserts 1 cycle. Branch and load-use together → ifid_flush_o=1 and idex_bubble_o=1.
- TIMEOUT=4, ack withheld → err_o rises after 4 REQ cycles and stays. A late ack then gives DONE; err_o stays 1 until rst_i.
- rst_i pulsed in 2nd REQ cycle → IDLE, ext_req_o=0, stall_cnt_o=0, err_o=0. Ack the next cycle has no effect.
